// File: rtl/rtc_ctrl.sv
// Command/data byte sequencer for a DS1302-style 3-wire RTC sitting on a byte SPI master.
// Expands one time read/write request into WP-clear + clock burst, with CE gaps and per-byte ack timeout.
module rtc_ctrl #(
  parameter int CE_GAP      = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        rd_start,
  input  logic        wr_start,
  input  logic [55:0] wr_time,
  output logic [55:0] rd_time,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        spi_ce,
  output logic        spi_wr_req,
  output logic [7:0]  spi_data_out,
  input  logic        spi_wr_ack,
  input  logic [7:0]  spi_data_recv
);
  localparam int GW = $clog2(CE_GAP + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WP_OFF, GAP, WBURST, RBURST, FINISH} state_e;

  state_e        state_q, state_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] to_q, to_d;
  logic [55:0]   wdata_q, wdata_d, shadow_q, shadow_d, rd_time_q, rd_time_d;
  logic          is_rd_q, is_rd_d, abort_q, abort_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          ce_q, ce_d, wr_req_q, wr_req_d;
  logic [7:0]    dout_q, dout_d;
  logic [3:0]    last_idx;

  function automatic logic [7:0] wburst_byte(input logic [3:0] idx, input logic [55:0] t);
    case (idx)
      4'd0:    wburst_byte = 8'hBE;
      4'd1:    wburst_byte = t[7:0];
      4'd2:    wburst_byte = t[15:8];
      4'd3:    wburst_byte = t[23:16];
      4'd4:    wburst_byte = t[31:24];
      4'd5:    wburst_byte = t[39:32];
      4'd6:    wburst_byte = t[47:40];
      4'd7:    wburst_byte = t[55:48];
      default: wburst_byte = 8'h80;
    endcase
  endfunction

  always_comb begin
    case (state_q)
      WP_OFF:  last_idx = 4'd1;
      WBURST:  last_idx = 4'd8;
      default: last_idx = 4'd7;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    gap_d     = gap_q;
    to_d      = to_q;
    wdata_d   = wdata_q;
    shadow_d  = shadow_q;
    rd_time_d = rd_time_q;
    is_rd_d   = is_rd_q;
    abort_d   = abort_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    ce_d      = ce_q;
    wr_req_d  = wr_req_q;
    dout_d    = dout_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // busy_q still high here means this is the done cycle; starts wait one more cycle
        if (!busy_q && (wr_start || rd_start)) begin
          wdata_d  = {wr_time[55:8], 1'b0, wr_time[6:0]};
          busy_d   = 1'b1;
          bcnt_d   = 4'd0;
          to_d     = '0;
          abort_d  = 1'b0;
          ce_d     = 1'b1;
          wr_req_d = 1'b1;
          is_rd_d  = !wr_start;
          state_d  = wr_start ? WP_OFF : RBURST;
          dout_d   = wr_start ? 8'h8E : 8'hBF;
        end
      end
      GAP: begin
        if (gap_q == GW'(CE_GAP - 1)) begin
          state_d  = WBURST;
          ce_d     = 1'b1;
          wr_req_d = 1'b1;
          dout_d   = 8'hBE;
          bcnt_d   = 4'd0;
          to_d     = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      FINISH: begin
        if (gap_q == GW'(CE_GAP - 1)) begin
          done_d  = 1'b1;
          err_d   = abort_q;
          state_d = IDLE;
          if (is_rd_q && !abort_q) rd_time_d = shadow_q;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        if (spi_wr_ack) begin
          to_d = '0;
          if (state_q == RBURST)
            for (int i = 0; i < 7; i++)
              if (bcnt_q == 4'(i + 1)) shadow_d[8*i +: 8] = spi_data_recv;
          if (bcnt_q == last_idx) begin
            ce_d    = 1'b0;
            gap_d   = '0;
            state_d = (state_q == WP_OFF) ? GAP : FINISH;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
            case (state_q)
              WP_OFF: begin wr_req_d = 1'b1; dout_d = 8'h00; end
              WBURST: begin wr_req_d = 1'b1; dout_d = wburst_byte(bcnt_q + 4'd1, wdata_q); end
              default: begin wr_req_d = 1'b0; dout_d = 8'h00; end
            endcase
          end
        end else if (to_q == TW'(ACK_TIMEOUT - 1)) begin
          ce_d    = 1'b0;
          gap_d   = '0;
          abort_d = 1'b1;
          state_d = FINISH;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      gap_q     <= '0;
      to_q      <= '0;
      wdata_q   <= '0;
      shadow_q  <= '0;
      rd_time_q <= '0;
      is_rd_q   <= 1'b0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ce_q      <= 1'b0;
      wr_req_q  <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      gap_q     <= gap_d;
      to_q      <= to_d;
      wdata_q   <= wdata_d;
      shadow_q  <= shadow_d;
      rd_time_q <= rd_time_d;
      is_rd_q   <= is_rd_d;
      abort_q   <= abort_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ce_q      <= ce_d;
      wr_req_q  <= wr_req_d;
      dout_q    <= dout_d;
    end
  end

  assign rd_time      = rd_time_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign spi_ce       = ce_q;
  assign spi_wr_req   = wr_req_q;
  assign spi_data_out = dout_q;
endmodule

// File: tb/tb_rtc_ctrl.sv
// Bench for rtc_ctrl: vector table of transactions, SPI master model, byte/result scoreboards.
module tb_rtc_ctrl;
  localparam int CE_GAP = 8;
  localparam int ACK_TO = 16;

  logic        sys_clk = 1'b0, rst_n = 1'b0, rd_start = 1'b0, wr_start = 1'b0;
  logic [55:0] wr_time = '0;
  logic [55:0] rd_time;
  logic        busy, done, err, spi_ce, spi_wr_req;
  logic [7:0]  spi_data_out;
  logic        spi_wr_ack;
  logic [7:0]  spi_data_recv;

  rtc_ctrl #(.CE_GAP(CE_GAP), .ACK_TIMEOUT(ACK_TO)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .rd_start(rd_start), .wr_start(wr_start),
    .wr_time(wr_time), .rd_time(rd_time), .busy(busy), .done(done), .err(err),
    .spi_ce(spi_ce), .spi_wr_req(spi_wr_req), .spi_data_out(spi_data_out),
    .spi_wr_ack(spi_wr_ack), .spi_data_recv(spi_data_recv)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // mode: 0 read, 1 write, 2 read+write together, 3 read w/o acks, 4 write w/o acks
  typedef struct { int mode; logic [55:0] wtime; logic [55:0] rdata; } vec_t;
  typedef struct { logic err; logic [55:0] rd; } res_t;

  logic [8:0]  exp_q[$];
  logic [7:0]  rq[$];
  res_t        res_q[$];
  int          pass_cnt = 0, tot_cnt = 0;
  int          ack_cnt = 0, done_cnt = 0, last_ack_cyc = 0;
  bit          ack_en = 1'b1, to_mode = 1'b0;
  logic [55:0] exp_rd_cur = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // SPI master model: takes each byte 4 cycles after CE/previous ack, checks it, acks
  initial begin : master
    int dly;
    logic [8:0] e;
    dly = 0;
    spi_wr_ack = 1'b0;
    spi_data_recv = 8'h00;
    forever begin
      @(posedge sys_clk); #1;
      spi_wr_ack = 1'b0;
      if (spi_ce && rst_n && ack_en) begin
        if (dly < 3) dly++;
        else begin
          dly = 0;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("byte", {55'd0, spi_wr_req, spi_data_out}, {55'd0, e});
          end else chk("byte_unexpected", exp_q.size(), 1);
          spi_data_recv = 8'h00;
          if (!spi_wr_req && rq.size() > 0) spi_data_recv = rq.pop_front();
          spi_wr_ack = 1'b1;
          ack_cnt++;
          last_ack_cyc = cyc;
        end
      end else dly = 0;
    end
  end

  // Monitor: CE run lengths, done/err results against the result queue
  initial begin : monitor
    bit ce_p, busy_p;
    int hi, lo;
    res_t r;
    ce_p = 0; busy_p = 0; hi = 0; lo = 0;
    forever begin
      @(posedge sys_clk); #1;
      if (!rst_n) begin
        ce_p = 0; busy_p = 0; hi = 0; lo = 0;
      end else begin
        if (spi_ce && !ce_p && busy_p) chk("ce_gap_len", lo, CE_GAP);
        if (!spi_ce && ce_p && to_mode) chk("timeout_ce_high", hi, ACK_TO);
        if (spi_ce) begin hi = ce_p ? hi + 1 : 1; lo = 0; end
        else lo = ce_p ? 1 : lo + 1;
        if (done) begin
          done_cnt++;
          if (res_q.size() > 0) begin
            r = res_q.pop_front();
            chk("done_err", err, r.err);
            chk("done_rd_time", rd_time, r.rd);
            chk("busy_at_done", busy, 1);
            if (!r.err) chk("done_latency", cyc - last_ack_cyc, CE_GAP + 1);
          end else chk("done_unexpected", res_q.size(), 1);
        end else if (err) chk("err_without_done", err, 0);
        ce_p = spi_ce;
        busy_p = busy;
      end
    end
  end

  task automatic push_bytes(input bit is_wr, input logic [55:0] w, input logic [55:0] rdata);
    if (is_wr) begin
      exp_q.push_back({1'b1, 8'h8E});
      exp_q.push_back({1'b1, 8'h00});
      exp_q.push_back({1'b1, 8'hBE});
      for (int k = 0; k < 7; k++) exp_q.push_back({1'b1, w[8*k +: 8]});
      exp_q.push_back({1'b1, 8'h80});
    end else begin
      exp_q.push_back({1'b1, 8'hBF});
      for (int k = 0; k < 7; k++) begin
        exp_q.push_back({1'b0, 8'h00});
        rq.push_back(rdata[8*k +: 8]);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit          is_wr = (v.mode == 1 || v.mode == 2 || v.mode == 4);
    bit          is_to = (v.mode >= 3);
    logic [55:0] w = {v.wtime[55:8], 1'b0, v.wtime[6:0]};
    int          d0 = done_cnt;
    bit          got = 0;
    res_t        r;
    ack_en = !is_to;
    to_mode = is_to;
    if (!is_to) push_bytes(is_wr, w, v.rdata);
    if (!is_wr && !is_to) exp_rd_cur = v.rdata;
    r.err = is_to;
    r.rd = exp_rd_cur;
    res_q.push_back(r);
    @(posedge sys_clk); #1;
    wr_time = v.wtime;
    wr_start = is_wr;
    rd_start = (v.mode == 0 || v.mode == 2 || v.mode == 3);
    @(posedge sys_clk); #1;
    wr_start = 0;
    rd_start = 0;
    wr_time = ~v.wtime;
    chk("busy_after_start", busy, 1);
    chk("ce_after_start", spi_ce, 1);
    chk("first_byte", {spi_wr_req, spi_data_out}, {1'b1, (is_wr ? 8'h8E : 8'hBF)});
    if (v.mode == 2) begin
      repeat (5) @(posedge sys_clk);
      #1 rd_start = 1;
      @(posedge sys_clk); #1 rd_start = 0;
    end
    for (int i = 0; i < 600 && !got; i++) begin
      @(posedge sys_clk); #2;
      if (done_cnt != d0) got = 1;
    end
    chk("done_seen", got, 1);
    repeat (3) @(posedge sys_clk);
    #2;
    chk("busy_clear", busy, 0);
    chk("one_done", done_cnt - d0, 1);
    chk("bytes_consumed", exp_q.size(), 0);
    chk("rd_time_hold", rd_time, exp_rd_cur);
  endtask

  initial begin : main
    vec_t vt[6];
    vec_t vr;
    bit   got;
    int   a0;
    vt[0] = '{0, 56'h0,              56'h24030907123045};
    vt[1] = '{1, 56'h24030907123085, 56'h0};
    vt[2] = '{2, 56'h99123123595959, 56'h0};
    vt[3] = '{3, 56'h0,              56'h0};
    vt[4] = '{0, 56'h0,              56'h99123123595958};
    vt[5] = '{4, 56'h11223344556677, 56'h0};

    #2;
    chk("rst_ce", spi_ce, 0);
    chk("rst_wr_req", spi_wr_req, 0);
    chk("rst_data_out", spi_data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_time", rd_time, 0);
    #20 rst_n = 1;

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Reset mid-WBURST, right after its 3rd ack
    ack_en = 1; to_mode = 0; got = 0; a0 = ack_cnt;
    push_bytes(1, 56'h24030907123005, 56'h0);
    @(posedge sys_clk); #1;
    wr_time = 56'h24030907123085;
    wr_start = 1;
    @(posedge sys_clk); #1 wr_start = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge sys_clk); #2;
      if (ack_cnt == a0 + 5) got = 1;
    end
    chk("reach_wburst_ack3", got, 1);
    @(posedge sys_clk); #3;
    rst_n = 0;
    #1;
    chk("midrst_ce", spi_ce, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_wr_req", spi_wr_req, 0);
    chk("midrst_data_out", spi_data_out, 0);
    chk("midrst_rd_time", rd_time, 0);
    exp_q.delete(); rq.delete(); res_q.delete();
    exp_rd_cur = '0;
    @(negedge sys_clk) rst_n = 1;
    vr = '{0, 56'h0, 56'h25120731235959};
    run_vec(vr);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
